// File: rtl/pwm_fade_wb.sv
// Wishbone-controlled PWM fader: steps CURRENT toward TARGET and writes each step to a PWM compare register.
// Optional macro PWM_FADE_TIMEOUT_EN adds a 256-cycle master acknowledge timeout (TOERR).
module pwm_fade_wb #(
  parameter int          CNT_BITS = 16,
  parameter int          IVL_BITS = 24,
  parameter logic [31:0] PWM_BASE = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  output logic        irq_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BUS} state_t;

  state_t state_q, state_d;

  logic [CNT_BITS-1:0] target_q, step_q, current_q, next_q;
  logic [CNT_BITS-1:0] step_eff, next_calc;
  logic [IVL_BITS-1:0] interval_q, ivl_cnt_q;
  logic                done_q, start_q, abort_q, abort_pend_q;
  logic                toerr_bit, timed_out;
  logic                access, wr_en, cfg_wr, busy, in_bus;
  logic [7:0]          adr;
  logic [31:0]         rd_data;
  logic                load_cnt, dec_cnt, latch_next, commit, set_done, clr_done;
  logic                unused_ok;

  assign unused_ok = ^{wb_adr_i[31:8], wb_dat_i};

  assign adr    = wb_adr_i[7:0];
  assign access = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr_en  = access & wb_we_i & (|wb_sel_i);
  assign busy   = (state_q != ST_IDLE);
  assign cfg_wr = wr_en & ~busy;
  assign in_bus = (state_q == ST_BUS);

  // One step toward TARGET, clamped so the fade never overshoots or wraps
  always_comb begin
    step_eff  = (step_q == '0) ? CNT_BITS'(1) : step_q;
    next_calc = target_q;
    if (current_q < target_q) begin
      if ((target_q - current_q) > step_eff) next_calc = current_q + step_eff;
    end else begin
      if ((current_q - target_q) > step_eff) next_calc = current_q - step_eff;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt   = 1'b0;
    dec_cnt    = 1'b0;
    latch_next = 1'b0;
    commit     = 1'b0;
    set_done   = 1'b0;
    clr_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          if (current_q == target_q) begin
            set_done = 1'b1;
          end else begin
            clr_done = 1'b1;
            load_cnt = 1'b1;
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (abort_q) begin
          state_d = ST_IDLE;
        end else if (ivl_cnt_q == '0) begin
          latch_next = 1'b1;
          state_d    = ST_BUS;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      ST_BUS: begin
        if (m_ack_i) begin
          commit = 1'b1;
          if (next_q == target_q) begin
            set_done = 1'b1;
            state_d  = ST_IDLE;
          end else if (abort_pend_q || abort_q) begin
            state_d = ST_IDLE;
          end else begin
            load_cnt = 1'b1;
            state_d  = ST_WAIT;
          end
        end else if (timed_out) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // CTRL bits are single-cycle pulses; ABORT wins over START in the same write
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      start_q <= wr_en && (adr == 8'h00) && wb_dat_i[0] && !wb_dat_i[1];
      abort_q <= wr_en && (adr == 8'h00) && wb_dat_i[1];
      if (!in_bus)      abort_pend_q <= 1'b0;
      else if (abort_q) abort_pend_q <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
      current_q  <= '0;
      next_q     <= '0;
      ivl_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      if (cfg_wr) begin
        case (adr)
          8'h04:   target_q   <= wb_dat_i[CNT_BITS-1:0];
          8'h08:   step_q     <= wb_dat_i[CNT_BITS-1:0];
          8'h0C:   interval_q <= wb_dat_i[IVL_BITS-1:0];
          8'h14:   current_q  <= wb_dat_i[CNT_BITS-1:0];
          default: ;
        endcase
      end
      if (commit) current_q <= next_q;
      if (latch_next) next_q <= next_calc;
      if (load_cnt)     ivl_cnt_q <= interval_q;
      else if (dec_cnt) ivl_cnt_q <= ivl_cnt_q - 1'b1;
      if (wr_en && (adr == 8'h10) && wb_dat_i[1]) done_q <= 1'b0;
      if (clr_done)      done_q <= 1'b0;
      else if (set_done) done_q <= 1'b1;
    end
  end

`ifdef PWM_FADE_TIMEOUT_EN
  logic [7:0] to_cnt_q;
  logic       toerr_q;

  assign timed_out = in_bus && !m_ack_i && (to_cnt_q == 8'hFF);
  assign toerr_bit = toerr_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt_q <= '0;
      toerr_q  <= 1'b0;
    end else begin
      if (!in_bus) to_cnt_q <= '0;
      else         to_cnt_q <= to_cnt_q + 1'b1;
      if (wr_en && (adr == 8'h10) && wb_dat_i[2]) toerr_q <= 1'b0;
      if (timed_out) toerr_q <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign toerr_bit = 1'b0;
`endif

  always_comb begin
    case (adr)
      8'h04:   rd_data = 32'(target_q);
      8'h08:   rd_data = 32'(step_q);
      8'h0C:   rd_data = 32'(interval_q);
      8'h10:   rd_data = {29'b0, toerr_bit, done_q, busy};
      8'h14:   rd_data = 32'(current_q);
      default: rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'h0;
    end else begin
      wb_ack_o <= access;
      if (access && !wb_we_i) wb_dat_o <= rd_data;
    end
  end

  // Master outputs are decoded from the state so a reset drops the cycle at once
  assign m_cyc_o = in_bus;
  assign m_stb_o = in_bus;
  assign m_we_o  = in_bus;
  assign m_sel_o = in_bus ? 4'hF : 4'h0;
  assign m_adr_o = in_bus ? (PWM_BASE + 32'h0000_000C) : 32'h0;
  assign m_dat_o = in_bus ? 32'(next_q) : 32'h0;
  assign irq_o   = done_q;

endmodule

// File: tb/tb_pwm_fade_wb.sv
// Randomized self-checking bench for pwm_fade_wb; a responder plays the PWM slave and a
// step-by-step arithmetic model predicts the sequence of compare writes.
module tb_pwm_fade_wb;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        wb_stb_i, wb_cyc_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic        m_ack_i;
  logic        irq_o;

  int checks = 0;
  int failures = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  int idle_run = 0;
  logic prev_cyc = 1'b0;

  logic [31:0] dat_q[$];
  logic [31:0] adr_q[$];
  logic [4:0]  attr_q[$];
  int          gap_q[$];

  pwm_fade_wb dut (
    .wb_clk_i(clk),
    .wb_rst_i(wb_rst_i),
    .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_we_i (wb_we_i),
    .wb_sel_i(wb_sel_i),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_ack_o(wb_ack_o),
    .wb_dat_o(wb_dat_o),
    .m_cyc_o (m_cyc_o),
    .m_stb_o (m_stb_o),
    .m_we_o  (m_we_o),
    .m_sel_o (m_sel_o),
    .m_adr_o (m_adr_o),
    .m_dat_o (m_dat_o),
    .m_ack_i (m_ack_i),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF;
    wb_adr_i = addr; wb_dat_i = data;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (wb_ack_o) break;
    end
    checkOutput("wb_write_ack", {31'b0, wb_ack_o}, 32'h1);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = 4'h0;
  endtask

  task automatic wb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_adr_i = addr;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (wb_ack_o) break;
    end
    data = wb_dat_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    logic [31:0] st;
    st = 32'h1;
    repeat (2) @(posedge clk);
    for (int n = 0; n < limit; n++) begin
      wb_read(32'h10, st);
      if (!st[0]) break;
    end
    checkOutput("idle_wait", {31'b0, st[0]}, 32'h0);
  endtask

  task automatic wait_bus(input int limit);
    for (int n = 0; n < limit; n++) begin
      @(posedge clk); #1;
      if (m_cyc_o) break;
    end
    checkOutput("bus_seen", {31'b0, m_cyc_o}, 32'h1);
  endtask

  // PWM-slave stand-in: acks after ack_delay cycles and logs each write and the idle gap before it
  initial begin
    m_ack_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!m_cyc_o) idle_run++;
      else if (!prev_cyc) begin
        gap_q.push_back(idle_run);
        idle_run = 0;
      end
      prev_cyc = m_cyc_o;
      if (m_ack_i) begin
        m_ack_i = 1'b0;
      end else if (m_cyc_o && m_stb_o) begin
        if (wait_cnt >= ack_delay) begin
          m_ack_i = 1'b1;
          wait_cnt = 0;
          dat_q.push_back(m_dat_o);
          adr_q.push_back(m_adr_o);
          attr_q.push_back({m_we_o, m_sel_o});
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic clear_logs();
    dat_q.delete(); adr_q.delete(); attr_q.delete(); gap_q.delete();
    idle_run = 0;
  endtask

  // Runs one complete fade and compares against the arithmetic model of the step sequence
  task automatic applyStimulus(input int cur, input int tgt, input int stp, input int ivl, input int dly);
    int exp_q[$];
    int c, s;
    logic [31:0] rd;
    ack_delay = dly;
    wb_write(32'h14, cur);
    wb_write(32'h04, tgt);
    wb_write(32'h08, stp);
    wb_write(32'h0C, ivl);
    clear_logs();
    wb_write(32'h00, 32'h1);
    wait_idle(4000);
    c = cur;
    s = (stp == 0) ? 1 : stp;
    while (c != tgt) begin
      if (c < tgt) c = (tgt - c <= s) ? tgt : c + s;
      else         c = (c - tgt <= s) ? tgt : c - s;
      exp_q.push_back(c);
    end
    checkOutput("fade_count", dat_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dat_q.size(); i++) begin
      checkOutput("fade_dat", dat_q[i], exp_q[i]);
      checkOutput("fade_adr", adr_q[i], 32'h0000_000C);
      checkOutput("fade_attr", {27'b0, attr_q[i]}, 32'h1F);
      if (i >= 1 && i < gap_q.size()) checkOutput("fade_gap", gap_q[i], ivl + 1);
    end
    wb_read(32'h10, rd);
    checkOutput("fade_status", rd, 32'h2);
    wb_read(32'h14, rd);
    checkOutput("fade_current", rd, tgt);
    checkOutput("fade_irq", {31'b0, irq_o}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    wb_rst_i = 1'b1;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = 4'h0;
    wb_adr_i = 32'h0; wb_dat_i = 32'h0;
    repeat (3) @(posedge clk);
    #1 wb_rst_i = 1'b0;

    wb_read(32'h10, rd);
    checkOutput("reset_status", rd, 32'h0);
    wb_read(32'h14, rd);
    checkOutput("reset_current", rd, 32'h0);
    checkOutput("reset_irq", {31'b0, irq_o}, 32'h0);
    checkOutput("reset_mcyc", {31'b0, m_cyc_o}, 32'h0);

    wb_write(32'h18, 32'hDEAD_BEEF);
    wb_read(32'h18, rd);
    checkOutput("unmapped_read", rd, 32'h0);
    wb_write(32'h04, 32'h1234);
    wb_read(32'h04, rd);
    checkOutput("target_rw", rd, 32'h1234);
    wb_read(32'h00, rd);
    checkOutput("ctrl_read", rd, 32'h0);

    applyStimulus(0, 10, 4, 2, 0);
    applyStimulus(100, 90, 0, 1, 1);

    // Already at target: no bus write, DONE the cycle after the START ack
    wb_write(32'h14, 5);
    wb_write(32'h04, 5);
    wb_write(32'h10, 32'h2);
    clear_logs();
    wb_write(32'h00, 32'h1);
    checkOutput("equal_irq_early", {31'b0, irq_o}, 32'h0);
    @(posedge clk); #1;
    checkOutput("equal_irq", {31'b0, irq_o}, 32'h1);
    repeat (5) @(posedge clk);
    checkOutput("equal_nowrite", gap_q.size(), 0);

    for (int k = 0; k < 6; k++) begin
      applyStimulus($urandom_range(200, 0), $urandom_range(200, 0), $urandom_range(40, 0),
                    $urandom_range(3, 0), $urandom_range(3, 0));
    end

    // Abort while the master write is waiting for a slow ack
    clear_logs();
    ack_delay = 5;
    wb_write(32'h14, 0); wb_write(32'h04, 100); wb_write(32'h08, 10); wb_write(32'h0C, 1);
    wb_write(32'h00, 32'h1);
    wait_bus(50);
    wb_write(32'h00, 32'h2);
    wait_idle(200);
    checkOutput("abort_bus_writes", dat_q.size(), 1);
    wb_read(32'h14, rd);
    checkOutput("abort_bus_current", rd, 32'd10);
    wb_read(32'h10, rd);
    checkOutput("abort_bus_status", rd, 32'h0);

    // Abort during WAIT, with config writes ignored while busy
    clear_logs();
    ack_delay = 0;
    wb_write(32'h08, 1); wb_write(32'h0C, 60);
    wb_write(32'h00, 32'h1);
    repeat (5) @(posedge clk);
    wb_write(32'h04, 7);
    wb_write(32'h00, 32'h3);
    wait_idle(50);
    checkOutput("abort_wait_writes", dat_q.size(), 0);
    wb_read(32'h04, rd);
    checkOutput("busy_target_kept", rd, 32'd100);
    wb_read(32'h14, rd);
    checkOutput("abort_wait_current", rd, 32'd10);

    // Slave never acknowledges
    clear_logs();
    ack_delay = 100000;
    wb_write(32'h14, 20); wb_write(32'h04, 30); wb_write(32'h08, 3); wb_write(32'h0C, 0);
    wb_write(32'h00, 32'h1);
    wait_bus(50);
`ifdef PWM_FADE_TIMEOUT_EN
    n = 1;
    while (m_cyc_o && n < 400) begin
      @(posedge clk); #1;
      if (m_cyc_o) n++;
    end
    checkOutput("timeout_cycles", n, 256);
    wb_read(32'h10, rd);
    checkOutput("timeout_status", rd, 32'h4);
    wb_read(32'h14, rd);
    checkOutput("timeout_current", rd, 32'd20);
    wb_write(32'h10, 32'h4);
    wb_read(32'h10, rd);
    checkOutput("toerr_clear", rd, 32'h0);
`else
    n = 0;
    repeat (300) @(posedge clk);
    #1;
    checkOutput("hold_cyc", {31'b0, m_cyc_o}, 32'h1);
    wb_read(32'h10, rd);
    checkOutput("hold_status", rd, 32'h1);
    @(posedge clk); #1;
    wb_rst_i = 1'b1;
    #1;
    checkOutput("rst_bus_cyc", {31'b0, m_cyc_o}, 32'h0);
    checkOutput("rst_bus_stb", {31'b0, m_stb_o}, 32'h0);
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
`endif
    ack_delay = 0;

    // Reset during WAIT clears outputs immediately and wipes the CSRs
    wb_write(32'h14, 0); wb_write(32'h04, 50); wb_write(32'h08, 1); wb_write(32'h0C, 40);
    wb_write(32'h00, 32'h1);
    wb_read(32'h04, rd);
    repeat (3) @(posedge clk);
    #1;
    wb_rst_i = 1'b1;
    #1;
    checkOutput("rst_wait_datout", wb_dat_o, 32'h0);
    checkOutput("rst_wait_ack", {31'b0, wb_ack_o}, 32'h0);
    checkOutput("rst_wait_mcyc", {31'b0, m_cyc_o}, 32'h0);
    checkOutput("rst_wait_madr", m_adr_o, 32'h0);
    checkOutput("rst_wait_irq", {31'b0, irq_o}, 32'h0);
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    wb_read(32'h04, rd);
    checkOutput("rst_target", rd, 32'h0);
    wb_read(32'h10, rd);
    checkOutput("rst_status", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
